bm_dag3_sig_collect: RTL
========================

# bm_dag3_sig_collect

Downstream consumer for the DAG3 microbenchmark. It captures the registered `out0`/`out1` result stream, skips a fixed pipeline warm-up window, and then compresses a programmable number of result samples into a 16-bit multiple-input signature register (MISR). The final signature is held for comparison against a golden value, so the benchmark synthesizes to a closed, self-checking netlist.

## Interface
- `BITS`, 2, width of the `out0` result bus; matches the upstream block
- `SIG_W`, 16, signature width
- `CNT_W`, 8, width of the sample-length counter
- `WARMUP`, 4, cycles discarded after start; covers the upstream pipeline depth
- `POLY`, 16'h1021, MISR feedback polynomial
- `SEED`, 16'hFFFF, signature value loaded when a run starts
- `clock`  in  1  single clock; all state updates on posedge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle run request
- `len`  in  CNT_W  number of samples to absorb; sampled with `start`
- `res0_in`  in  BITS  upstream `out0`
- `res1_in`  in  1  upstream `out1`
- `busy`  out  1  high in WARM and COLLECT
- `sig_valid`  out  1  high in DONE
- `signature`  out  SIG_W  MISR contents
- `sample_cnt`  out  CNT_W  samples absorbed so far in the current run

## Operation
- FSM states: IDLE, WARM, COLLECT, DONE. `reset_n` low forces IDLE immediately.
- Reset values: `busy` 0, `sig_valid` 0, `signature` 0, `sample_cnt` 0, warm-up counter 0.
- IDLE, `start` high: latch `len`, load `signature` with SEED, clear `sample_cnt`, go to WARM.
- WARM: count WARMUP edges and ignore the inputs.
  - After the WARMUP-th edge, go to COLLECT if the latched len is nonzero.
  - If the latched len is 0, go to DONE instead; the signature stays SEED.
- COLLECT: each edge absorbs one sample and increments `sample_cnt`. The edge that absorbs sample `len` also moves the FSM to DONE.
- MISR update for one sample:
  - data word `d` = zero-extended {res1_in, res0_in}, (BITS+1) bits
  - next = (sig << 1, truncated to SIG_W) ^ (sig[SIG_W-1] ? POLY : 0) ^ d
- DONE: `signature` and `sample_cnt` hold. `start` high restarts the run exactly as from IDLE, on the same edge.
- `start` is ignored in WARM and COLLECT; the run in progress is not disturbed.
- `len` is ignored except on the edge that accepts `start`.
- Counter wrap: `sample_cnt` never exceeds the latched len, so no wrap occurs. len = 2^CNT_W−1 is legal.

## Timing
- Edge E0 accepts `start`: `busy` rises after E0.
- Edges E1..E_WARMUP: inputs discarded.
- Edges E_(WARMUP+1)..E_(WARMUP+len): samples absorbed, one per edge, no stalls.
- After E_(WARMUP+len): `busy` falls and `sig_valid` rises. Total start-to-valid latency is WARMUP+len edges; for len = 0 it is WARMUP edges.
- DONE with `start`: `sig_valid` falls and `busy` rises after the same edge, with no idle gap.
- `reset_n` asserted mid-run: all outputs return to reset values asynchronously; the partial signature is lost. Deassertion is synchronous to `clock` at the system level.

## Structure
- Shared package `bm_dag3_pkg`:
  - FSM state encoding (2-bit: IDLE=0, WARM=1, COLLECT=2, DONE=3)
  - POLY and SEED defaults
  - BITS default, shared with the upstream block
- One sub-module, `bm_misr_step`: purely combinational next-signature function, parameterized by SIG_W, POLY and data width. Owns the arithmetic so it can be unit-tested alone.
- Top level holds the FSM, the warm-up counter, the sample counter, and the registers for latched len and signature.

## Test plan
- Reset, then idle with no `start` -> all outputs 0 indefinitely; input toggling has no effect.
- `start`, len=1, WARMUP=4, res0=0 and res1=0 at E5 -> `sig_valid` high after E5, `signature`=16'hEFDF, `sample_cnt`=1.
- Same run with res0=3, res1=1 at E5 -> `signature`=16'hEFD8; any input values at E1..E4 do not change the result.
- len=0 -> `sig_valid` after E4, `signature`=16'hFFFF, `sample_cnt`=0; `start` pulsed during WARM is ignored.
- len=8 run with `reset_n` pulsed low at E6 -> outputs 0 immediately, FSM in IDLE; a fresh len=1 zero-data run then yields 16'hEFDF.
- len=255 constant-zero run, then `start` asserted in DONE -> `sample_cnt` reaches 255 with no wrap, `signature` matches the software MISR model, and the restart drops `sig_valid` and raises `busy` on the same edge.

Source files
------------

// File: rtl/bm_dag3_pkg.sv
// Shared definitions for the DAG3 microbenchmark: FSM encoding and the
// default result width, MISR polynomial and seed used by both ends.
package bm_dag3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARM    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int          BITS_DEF = 2;
    localparam logic [15:0] POLY_DEF = 16'h1021;
    localparam logic [15:0] SEED_DEF = 16'hFFFF;

endpackage

// File: rtl/bm_misr_step.sv
// One MISR step: shift left, fold the polynomial in when the MSB falls out,
// then XOR in the zero-extended data word. Purely combinational.
module bm_misr_step
    import bm_dag3_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = POLY_DEF,
    parameter int               D_W   = BITS_DEF + 1
) (
    input  logic [SIG_W-1:0] i_sig,
    input  logic [D_W-1:0]   i_data,
    output logic [SIG_W-1:0] o_next
);

    logic [SIG_W-1:0] w_data_ext;
    logic [SIG_W-1:0] w_feedback;

    assign w_data_ext = SIG_W'(i_data);
    assign w_feedback = i_sig[SIG_W-1] ? POLY : '0;
    assign o_next     = {i_sig[SIG_W-2:0], 1'b0} ^ w_feedback ^ w_data_ext;

endmodule

// File: rtl/bm_dag3_sig_collect.sv
// Result-stream signature collector: discards WARMUP cycles after start, then
// folds len samples of {res1_in, res0_in} into a MISR and holds the result.
module bm_dag3_sig_collect
    import bm_dag3_pkg::*;
#(
    parameter int               BITS   = BITS_DEF,
    parameter int               SIG_W  = 16,
    parameter int               CNT_W  = 8,
    parameter int               WARMUP = 4,
    parameter logic [SIG_W-1:0] POLY   = POLY_DEF,
    parameter logic [SIG_W-1:0] SEED   = SEED_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [BITS-1:0]  res0_in,
    input  logic             res1_in,
    output logic             busy,
    output logic             sig_valid,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam int              WARM_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_sample_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [SIG_W-1:0]   r_sig;
    logic [SIG_W-1:0]   w_sig_next;
    logic [WARM_W-1:0]  r_warm_cnt;
    logic               w_accept;
    logic               w_warm_done;
    logic               w_last_sample;

    assign w_cnt_inc     = r_sample_cnt + CNT_W'(1);
    assign w_warm_done   = (r_warm_cnt == WARM_LAST);
    assign w_last_sample = (w_cnt_inc == r_len);

    assign signature  = r_sig;
    assign sample_cnt = r_sample_cnt;

    bm_misr_step #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .D_W   (BITS + 1)
    ) u_misr_step (
        .i_sig  (r_sig),
        .i_data ({res1_in, res0_in}),
        .o_next (w_sig_next)
    );

    // State register; reset lands in IDLE immediately.
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state and status outputs; start only counts in IDLE or DONE.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        sig_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_WARM;
                end
            end
            ST_WARM: begin
                busy = 1'b1;
                if (w_warm_done)
                    w_next_state = (r_len == '0) ? ST_DONE : ST_COLLECT;
            end
            ST_COLLECT: begin
                busy = 1'b1;
                if (w_last_sample) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                sig_valid = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_WARM;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: arm a run on accept, count warm-up, absorb samples in COLLECT.
    // NOTE: r_len is reset too, so nothing reads an unknown before first start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_len        <= '0;
            r_sig        <= '0;
            r_sample_cnt <= '0;
            r_warm_cnt   <= '0;
        end else if (w_accept) begin
            r_len        <= len;
            r_sig        <= SEED;
            r_sample_cnt <= '0;
            r_warm_cnt   <= '0;
        end else if (r_state == ST_WARM) begin
            r_warm_cnt <= w_warm_done ? '0 : r_warm_cnt + WARM_W'(1);
        end else if (r_state == ST_COLLECT) begin
            r_sig        <= w_sig_next;
            r_sample_cnt <= w_cnt_inc;
        end
    end

endmodule
